// File: rtl/hex_loader.sv
// Intel HEX stream decoder: parses ASCII records one character per in_valid
// and turns type-00 data bytes into byte writes at base + offset + index.
module hex_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter bit          CHECK_SUM  = 1'b1
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  write_en,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [7:0]            write_data,
  output logic [31:0]           byte_count,
  output logic                  done,
  output logic                  checksum_err,
  output logic                  format_err
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen  = 3'd1;
  localparam logic [2:0] StOffs = 3'd2;
  localparam logic [2:0] StType = 3'd3;
  localparam logic [2:0] StData = 3'd4;
  localparam logic [2:0] StCsum = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  localparam logic [7:0] Colon = 8'h3A;

  // Address bits that must be clear for a byte to land inside the window.
  localparam logic [31:0] HiMask =
      (ADDR_WIDTH >= 32) ? 32'h0 : ~((32'h1 << ADDR_WIDTH) - 32'h1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [11:0] acc_q, acc_d;
  logic [7:0]  len_q, len_d;
  logic [15:0] offs_q, offs_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] ext_q, ext_d;
  logic [31:0] base_q, base_d;

  logic                  write_en_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [7:0]            write_data_q;
  logic [31:0]           byte_count_q;
  logic                  done_q;
  logic                  checksum_err_q;
  logic                  format_err_q;

  logic        hex_ok;
  logic [3:0]  nib;
  logic [7:0]  byte_val;
  logic [7:0]  csum_final;
  logic [31:0] byte_addr;
  logic        type_ok;
  logic        wr_fire;
  logic        set_done;
  logic        set_cs;
  logic        set_fmt;

  // ASCII hex digit decode; letters map through their low nibble plus 9.
  always_comb begin
    hex_ok = 1'b1;
    nib    = 4'h0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      nib = in_data[3:0];
    end else if ((in_data >= 8'h41 && in_data <= 8'h46) ||
                 (in_data >= 8'h61 && in_data <= 8'h66)) begin
      nib = in_data[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  assign byte_val   = {acc_q[3:0], nib};
  assign csum_final = sum_q + byte_val;
  assign byte_addr  = base_q + {16'h0, offs_q} + {24'h0, idx_q};

  always_comb begin
    type_ok = 1'b0;
    unique case (byte_val)
      8'h00, 8'h01, 8'h03, 8'h05: type_ok = 1'b1;
      8'h02, 8'h04:               type_ok = (len_q == 8'd2);
      default:                    type_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    acc_d     = acc_q;
    len_d     = len_q;
    offs_d    = offs_q;
    type_d    = type_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    ext_d     = ext_q;
    base_d    = base_q;
    wr_fire   = 1'b0;
    set_done  = 1'b0;
    set_cs    = 1'b0;
    set_fmt   = 1'b0;

    if (in_valid && state_q != StDone) begin
      if (in_data == Colon) begin
        state_d   = StLen;
        nib_cnt_d = 2'd0;
        sum_d     = 8'h00;
      end else if (state_q == StIdle) begin
        state_d = StIdle;
      end else if (!hex_ok) begin
        set_fmt = 1'b1;
        state_d = StIdle;
      end else begin
        acc_d     = {acc_q[7:0], nib};
        nib_cnt_d = nib_cnt_q + 2'd1;
        if (nib_cnt_q[0]) begin
          sum_d = csum_final;
        end
        case (state_q)
          StLen: begin
            if (nib_cnt_q == 2'd1) begin
              len_d     = byte_val;
              nib_cnt_d = 2'd0;
              state_d   = StOffs;
            end
          end
          StOffs: begin
            if (nib_cnt_q == 2'd3) begin
              offs_d    = {acc_q[11:0], nib};
              nib_cnt_d = 2'd0;
              state_d   = StType;
            end
          end
          StType: begin
            if (nib_cnt_q == 2'd1) begin
              type_d    = byte_val;
              idx_d     = 8'd0;
              ext_d     = 16'h0;
              nib_cnt_d = 2'd0;
              if (!type_ok) begin
                set_fmt = 1'b1;
                state_d = StIdle;
              end else if (len_q == 8'd0) begin
                state_d = StCsum;
              end else begin
                state_d = StData;
              end
            end
          end
          StData: begin
            if (nib_cnt_q[0]) begin
              nib_cnt_d = 2'd0;
              ext_d     = {ext_q[7:0], byte_val};
              if (type_q == 8'h00 && (byte_addr & HiMask) == 32'h0) begin
                wr_fire = 1'b1;
              end
              idx_d = idx_q + 8'd1;
              if (idx_q == len_q - 8'd1) begin
                state_d = StCsum;
              end
            end
          end
          StCsum: begin
            if (nib_cnt_q[0]) begin
              nib_cnt_d = 2'd0;
              state_d   = StIdle;
              if (CHECK_SUM && csum_final != 8'h00) begin
                set_cs = 1'b1;
              end
              if (type_q == 8'h01 && (csum_final == 8'h00 || !CHECK_SUM)) begin
                set_done = 1'b1;
                state_d  = StDone;
              end
              // Base only takes effect for records that follow this one.
              if (type_q == 8'h02) begin
                base_d = {12'h0, ext_q, 4'h0};
              end else if (type_q == 8'h04) begin
                base_d = {ext_q, 16'h0};
              end
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      nib_cnt_q      <= 2'd0;
      acc_q          <= 12'h0;
      len_q          <= 8'h0;
      offs_q         <= 16'h0;
      type_q         <= 8'h0;
      idx_q          <= 8'h0;
      sum_q          <= 8'h0;
      ext_q          <= 16'h0;
      base_q         <= 32'h0;
      write_en_q     <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= 8'h0;
      byte_count_q   <= 32'h0;
      done_q         <= 1'b0;
      checksum_err_q <= 1'b0;
      format_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      nib_cnt_q      <= nib_cnt_d;
      acc_q          <= acc_d;
      len_q          <= len_d;
      offs_q         <= offs_d;
      type_q         <= type_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      ext_q          <= ext_d;
      base_q         <= base_d;
      write_en_q     <= wr_fire;
      done_q         <= done_q | set_done;
      checksum_err_q <= checksum_err_q | set_cs;
      format_err_q   <= format_err_q | set_fmt;
      if (wr_fire) begin
        write_addr_q <= byte_addr[ADDR_WIDTH-1:0];
        write_data_q <= byte_val;
        byte_count_q <= byte_count_q + 32'd1;
      end
    end
  end

  assign write_en     = write_en_q;
  assign write_addr   = write_addr_q;
  assign write_data   = write_data_q;
  assign byte_count   = byte_count_q;
  assign done         = done_q;
  assign checksum_err = checksum_err_q;
  assign format_err   = format_err_q;

endmodule
